add_nbit_seq: RTL and testbench

- Parametrised digit-serial ALU slice; successor to the team's single-bit combinational gate cell.
- Adds, subtracts, ANDs or ORs two WIDTH-bit operands, DIGIT bits per clock, through a valid/ready handshake on input and output.
- Produces registered result, carry and signed-overflow flags.
- Sits between operand sources and result consumers where area matters more than single-cycle latency.

---
 rtl/add_nbit_seq.sv | 117 +++++++++++
 tb/tb_add_nbit_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_nbit_seq.sv
// Digit-serial ALU slice: ADD/SUB/AND/OR on WIDTH-bit operands, DIGIT bits per clock,
// with valid/ready handshakes on both sides and registered result/carry/overflow.
module add_nbit_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] y_out,
  output logic             carry_out,
  output logic             ovf_out
);

  localparam int N  = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
      $error("add_nbit_seq: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q, y_q;
  logic [1:0]        op_q;
  logic              carry_q, carryFlag_q, ovfFlag_q, outValid_q;

  logic [DIGIT-1:0]  aDig, bDig, digitRes;
  logic [DIGIT:0]    digitSum;
  logic [WIDTH-1:0]  res_d;
  logic              carry_d, ovf_d;
  int                digIdx;

  always_comb begin
    digIdx   = int'(cnt_q) * DIGIT;
    aDig     = a_q[digIdx +: DIGIT];
    bDig     = b_q[digIdx +: DIGIT];
    digitSum = {1'b0, aDig} + {1'b0, bDig} + (DIGIT+1)'(carry_q);
    case (op_q)
      2'b10:   digitRes = aDig & bDig;
      2'b11:   digitRes = aDig | bDig;
      default: digitRes = digitSum[DIGIT-1:0];
    endcase
    carry_d = op_q[1] ? 1'b0 : digitSum[DIGIT];
    res_d   = res_q;
    res_d[digIdx +: DIGIT] = digitRes;
    // b_q already holds ~B for SUB, so one "same sign in, different sign out" rule covers both
    ovf_d = !op_q[1] && (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      carry_q     <= 1'b0;
      res_q       <= '0;
      y_q         <= '0;
      carryFlag_q <= 1'b0;
      ovfFlag_q   <= 1'b0;
      outValid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_in) begin
            a_q     <= a_in;
            b_q     <= (op_in == 2'b01) ? ~b_in : b_in;
            op_q    <= op_in;
            carry_q <= (op_in == 2'b01);
            cnt_q   <= '0;
            res_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          res_q   <= res_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            y_q         <= res_d;
            carryFlag_q <= carry_d;
            ovfFlag_q   <= ovf_d;
            outValid_q  <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_in) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_out  = (state_q == IDLE) && rst_n_in;
  assign out_valid_out = outValid_q;
  assign y_out         = y_q;
  assign carry_out     = carryFlag_q;
  assign ovf_out       = ovfFlag_q;

endmodule

// File: tb/tb_add_nbit_seq.sv
// Self-checking bench for add_nbit_seq (WIDTH=16, DIGIT=4): directed plan cases,
// randomized operations against an arithmetic reference model, backpressure and mid-op reset.
module tb_add_nbit_seq;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic             clk = 1'b0;
  logic             rstN;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] aIn, bIn;
  logic [1:0]       opIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] yOut;
  logic             carryOut;
  logic             ovfOut;

  int checkCount = 0;
  int passCount  = 0;

  add_nbit_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk_in        (clk),
    .rst_n_in      (rstN),
    .in_valid_in   (inValid),
    .in_ready_out  (inReady),
    .a_in          (aIn),
    .b_in          (bIn),
    .op_in         (opIn),
    .out_valid_out (outValid),
    .out_ready_in  (outReady),
    .y_out         (yOut),
    .carry_out     (carryOut),
    .ovf_out       (ovfOut)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, result packed as {carry, ovf, y}
  function automatic logic [WIDTH+1:0] refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [1:0] op);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] y;
    logic             c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        y    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y = a - b;
        c = (a >= b);
        v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  y = a & b;
      default: y = a | b;
    endcase
    return {c, v, y};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] check %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for in_ready, presents one operation and returns #1 after the accept edge
  task automatic acceptOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
    int waited = 0;
    @(negedge clk);
    while (!inReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_before_op", 32'(inReady), 32'd1);
    aIn     = a;
    bIn     = b;
    opIn    = op;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Counts edges until out_valid, scrambling the operand inputs meanwhile
  task automatic waitForValid(output int latency);
    latency = 0;
    while (!outValid && latency < 20) begin
      aIn     = WIDTH'($urandom);
      bIn     = WIDTH'($urandom);
      opIn    = 2'($urandom);
      inValid = 1'($urandom);
      @(posedge clk);
      #1;
      latency++;
    end
    inValid = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [1:0] op, input logic [WIDTH-1:0] expY,
                               input logic expC, input logic expV);
    int latency;
    acceptOp(a, b, op);
    waitForValid(latency);
    checkOutput({tag, "_latency"}, 32'(latency), 32'(N));
    checkOutput({tag, "_y"},       32'(yOut),     32'(expY));
    checkOutput({tag, "_carry"},   32'(carryOut), 32'(expC));
    checkOutput({tag, "_ovf"},     32'(ovfOut),   32'(expV));
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] ra, rb;
    logic [1:0]       rop;
    int               latency;

    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    aIn      = '0;
    bIn      = '0;
    opIn     = OP_ADD;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_in_ready",  32'(inReady),  32'd0);
    checkOutput("reset_y",         32'(yOut),     32'd0);
    checkOutput("reset_flags",     32'({carryOut, ovfOut}), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(inReady), 32'd1);

    applyStimulus("add_basic",  16'h1234, 16'h0FFF, OP_ADD, 16'h2233, 1'b0, 1'b0);
    applyStimulus("add_carry",  16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b0);
    applyStimulus("add_ovf",    16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1);
    applyStimulus("sub_borrow", 16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, 1'b0);
    applyStimulus("sub_ovf",    16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1, 1'b1);
    applyStimulus("and_basic",  16'hF0F0, 16'h3C3C, OP_AND, 16'h3030, 1'b0, 1'b0);
    applyStimulus("or_basic",   16'hF0F0, 16'h0F0F, OP_OR,  16'hFFFF, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rop = 2'($urandom);
      exp = refModel(ra, rb, rop);
      applyStimulus($sformatf("rand%0d", i), ra, rb, rop, exp[WIDTH-1:0], exp[WIDTH+1], exp[WIDTH]);
    end

    // Backpressure: result must sit untouched while the consumer stalls
    ra  = WIDTH'($urandom);
    rb  = WIDTH'($urandom);
    exp = refModel(ra, rb, OP_ADD);
    acceptOp(ra, rb, OP_ADD);
    waitForValid(latency);
    checkOutput("bp_latency", 32'(latency), 32'(N));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      aIn     = ~aIn;
      inValid = ~inValid;
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 32'(outValid), 32'd1);
      checkOutput("bp_y",         32'(yOut),     32'(exp[WIDTH-1:0]));
      checkOutput("bp_in_ready",  32'(inReady),  32'd0);
    end
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("bp_release_valid", 32'(outValid), 32'd0);
    checkOutput("bp_release_ready", 32'(inReady),  32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp_no_extra", 32'(outValid), 32'd0);

    // Reset during the second BUSY cycle aborts the operation
    applyStimulus("pre_reset", 16'h1234, 16'h0FFF, OP_ADD, 16'h2233, 1'b0, 1'b0);
    acceptOp(16'h1111, 16'h2222, OP_ADD);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rst_forces_ready_low", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_mid_valid", 32'(outValid), 32'd0);
    checkOutput("rst_mid_y",     32'(yOut),     32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_valid", 32'(outValid), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("rst_release_ready", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rst_release_idle_valid", 32'(outValid), 32'd0);
    applyStimulus("post_reset", 16'h0001, 16'h0001, OP_ADD, 16'h0002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
